// File: rtl/barcode_frame_decoder.sv
// Serial bar-code frame decoder: learns the module width from the start guard,
// samples each module at its midpoint, checks guards/parity and emits a 5-bit code.
module barcode_frame_decoder #(
    parameter int CW          = 8,
    parameter int MIN_W       = 4,
    parameter int MAX_W       = 200,
    parameter int IDLE_CYCLES = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       bar_in,
    output logic [4:0] code,
    output logic       code_valid,
    output logic       err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_MEASURE = 2'd1,
        ST_SAMPLE  = 2'd2
    } state_t;

    // Width counter carries one extra bit so MAX_W+1 always fits.
    localparam logic [CW:0]   MIN_C  = (CW+1)'(MIN_W);
    localparam logic [CW:0]   MAX_C  = (CW+1)'(MAX_W);
    localparam logic [CW-1:0] IDLE_C = CW'(IDLE_CYCLES);

    function automatic logic even_parity_ok(input logic [4:0] d, input logic p);
        return ~(^{d, p});
    endfunction

    logic          r_sync1, r_s;
    state_t        r_state, w_state_nx;
    logic [CW-1:0] r_idle, w_idle_nx;
    logic [CW:0]   r_width, w_width_nx;
    logic [CW-1:0] r_w, w_w_nx;
    logic [CW-1:0] r_phase, w_phase_nx;
    logic [3:0]    r_m, w_m_nx;
    logic [4:0]    r_data, w_data_nx;
    logic          r_par, w_par_nx;
    logic [4:0]    r_code, w_code_nx;
    logic          r_valid, w_valid_nx;
    logic          r_err, w_err_nx;
    logic          r_busy, w_busy_nx;
    logic          w_sample;

    assign w_sample = (r_phase == (r_w >> 1));

    // Next-state and next-output computation for the frame FSM.
    always_comb begin
        w_state_nx = r_state;
        w_idle_nx  = r_idle;
        w_width_nx = r_width;
        w_w_nx     = r_w;
        w_phase_nx = r_phase;
        w_m_nx     = r_m;
        w_data_nx  = r_data;
        w_par_nx   = r_par;
        w_code_nx  = r_code;
        w_valid_nx = 1'b0;
        w_err_nx   = 1'b0;
        w_busy_nx  = r_busy;
        case (r_state)
            ST_ARM: begin
                if (r_s) begin
                    w_idle_nx = {CW{1'b0}};
                    if (r_idle == IDLE_C) begin
                        w_state_nx = ST_MEASURE;
                        w_width_nx = {{CW{1'b0}}, 1'b1};
                        w_busy_nx  = 1'b1;
                    end else begin
                        w_state_nx = ST_ARM;
                    end
                end else if (r_idle != IDLE_C) begin
                    w_idle_nx = r_idle + CW'(1);
                end else begin
                    w_idle_nx = r_idle;
                end
            end
            ST_MEASURE: begin
                if (r_s) begin
                    if (r_width <= MAX_C) begin
                        w_width_nx = r_width + (CW+1)'(1);
                    end else begin
                        w_width_nx = r_width;
                    end
                end else if (r_width < MIN_C || r_width > MAX_C) begin
                    w_state_nx = ST_ARM;
                    w_idle_nx  = {CW{1'b0}};
                    w_err_nx   = 1'b1;
                    w_busy_nx  = 1'b0;
                end else begin
                    w_state_nx = ST_SAMPLE;
                    w_w_nx     = r_width[CW-1:0];
                    w_phase_nx = CW'(1);
                    w_m_nx     = 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (r_phase == r_w - CW'(1)) begin
                    w_phase_nx = {CW{1'b0}};
                    w_m_nx     = r_m + 4'd1;
                end else begin
                    w_phase_nx = r_phase + CW'(1);
                end
                if (w_sample) begin
                    case (r_m)
                        4'd1:    w_err_nx = r_s;
                        4'd2:    w_err_nx = ~r_s;
                        4'd3, 4'd4, 4'd5, 4'd6, 4'd7:
                                 w_data_nx = {r_data[3:0], r_s};
                        4'd8:    w_par_nx = r_s;
                        4'd9: begin
                            if (r_s && even_parity_ok(r_data, r_par)) begin
                                w_valid_nx = 1'b1;
                                w_code_nx  = r_data;
                            end else begin
                                w_err_nx = 1'b1;
                            end
                        end
                        default: w_err_nx = 1'b1;
                    endcase
                end else begin
                    w_err_nx = 1'b0;
                end
                if (w_err_nx || w_valid_nx) begin
                    w_state_nx = ST_ARM;
                    w_idle_nx  = {CW{1'b0}};
                    w_busy_nx  = 1'b0;
                end else begin
                    w_state_nx = ST_SAMPLE;
                end
            end
            default: begin
                w_state_nx = ST_ARM;
                w_idle_nx  = {CW{1'b0}};
                w_busy_nx  = 1'b0;
            end
        endcase
    end

    // Synchronizer and FSM state/output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
            r_state <= ST_ARM;
            r_idle  <= {CW{1'b0}};
            r_width <= {(CW+1){1'b0}};
            r_w     <= {CW{1'b0}};
            r_phase <= {CW{1'b0}};
            r_m     <= 4'd0;
            r_data  <= 5'd0;
            r_par   <= 1'b0;
            r_code  <= 5'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_sync1 <= bar_in;
            r_s     <= r_sync1;
            r_state <= w_state_nx;
            r_idle  <= w_idle_nx;
            r_width <= w_width_nx;
            r_w     <= w_w_nx;
            r_phase <= w_phase_nx;
            r_m     <= w_m_nx;
            r_data  <= w_data_nx;
            r_par   <= w_par_nx;
            r_code  <= w_code_nx;
            r_valid <= w_valid_nx;
            r_err   <= w_err_nx;
            r_busy  <= w_busy_nx;
        end
    end

    assign code       = r_code;
    assign code_valid = r_valid;
    assign err        = r_err;
    assign busy       = r_busy;

endmodule

// File: tb/tb_barcode_frame_decoder.sv
// Scoreboard bench: frames are described at module level, the expected outcome is
// derived from the frame rules and queued; a monitor checks every strobe.
module tb_barcode_frame_decoder;

    localparam int MIN_W = 4;
    localparam int MAX_W = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       bar_in = 1'b0;
    logic [4:0] code;
    logic       code_valid, err, busy;

    typedef struct {
        bit         acc;
        int         cyc;
        logic [4:0] code;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [4:0] model_code = 5'd0;
    bit         watch_busy = 1'b0, busy_seen = 1'b0;
    bit         chk_rst = 1'b0, chk_idle = 1'b0, chk_end = 1'b0;

    barcode_frame_decoder #(.CW(8), .MIN_W(MIN_W), .MAX_W(MAX_W), .IDLE_CYCLES(16)) dut (
        .clock(clock), .reset(reset), .bar_in(bar_in),
        .code(code), .code_valid(code_valid), .err(err), .busy(busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: owns all comparisons; stimulus only raises request flags.
    always @(negedge clock) begin
        if (watch_busy && busy) busy_seen = 1'b1;
        if (chk_rst) begin
            chk("rst_code", code, 0);
            chk("rst_valid", code_valid, 0);
            chk("rst_err", err, 0);
            chk("rst_busy", busy, 0);
        end
        if (chk_idle) chk("ignored_frame_busy", busy_seen, 0);
        if (chk_end) chk("queue_empty", exp_q.size(), 0);
        if (!reset && (code_valid || err)) begin
            chk("exclusive", int'(code_valid & err), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("kind", code_valid, mon_e.acc);
                chk("time", cyc, mon_e.cyc);
                chk("code", code, mon_e.code);
                chk("busy_fall", busy, 0);
            end
        end
    end

    task automatic drive(input logic level, input int n);
        repeat (n) begin
            bar_in = level;
            @(posedge clock); #1;
        end
    endtask

    // fault: 0 none, 1 parity flipped, 2 second guard white, 3 stop white.
    task automatic send_frame(input int w, input logic [4:0] d, input int fault, input bit expect_it);
        logic lv[10];
        int   n, ones, fail_m, last_mod;
        exp_t e;
        lv[0] = 1'b1; lv[1] = 1'b0; lv[2] = 1'b1;
        for (int i = 0; i < 5; i++) lv[3+i] = d[4-i];
        lv[8] = ^d;
        lv[9] = 1'b1;
        if (fault == 1) lv[8] = ~lv[8];
        if (fault == 2) lv[2] = 1'b0;
        if (fault == 3) lv[9] = 1'b0;
        n = cyc;
        e.code = model_code;
        if (w < MIN_W || w > MAX_W) begin
            e.acc = 0; e.cyc = n + w + 3; last_mod = 0;
        end else begin
            ones = 0;
            for (int i = 3; i <= 8; i++) ones += int'(lv[i]);
            if (lv[1] != 1'b0) fail_m = 1;
            else if (lv[2] != 1'b1) fail_m = 2;
            else if (lv[9] != 1'b1 || (ones % 2) != 0) fail_m = 9;
            else fail_m = 0;
            e.acc = (fail_m == 0);
            last_mod = e.acc ? 9 : fail_m;
            e.cyc = n + w + 2 + (last_mod - 1) * w + w / 2 + 1;
            if (e.acc) begin
                e.code = d;
                model_code = d;
            end
        end
        if (expect_it) exp_q.push_back(e);
        if (w < MIN_W || w > MAX_W) drive(1'b1, w);
        else for (int m = 0; m <= last_mod; m++) drive(lv[m], w);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        bar_in = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_code = 5'd0;
        chk_rst = 1'b1;
        @(negedge clock); #1;
        chk_rst = 1'b0;
    endtask

    initial begin
        int w, fault, sel;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk_rst = 1'b1;
        @(negedge clock); #1;
        chk_rst = 1'b0;

        drive(1'b0, 20); send_frame(8, 5'b10110, 0, 1'b1);
        drive(1'b0, 20); send_frame(8, 5'b10110, 1, 1'b1);
        drive(1'b0, 20); send_frame(3, 5'b00000, 0, 1'b1);
        drive(1'b0, 20); send_frame(250, 5'b00000, 0, 1'b1);

        // Short gap: the second frame must be ignored, then decode after 16 white.
        drive(1'b0, 20); send_frame(8, 5'b01101, 0, 1'b1);
        watch_busy = 1'b1;
        drive(1'b0, 5); send_frame(8, 5'b10110, 0, 1'b0);
        drive(1'b0, 3);
        watch_busy = 1'b0;
        chk_idle = 1'b1;
        @(negedge clock); #1;
        chk_idle = 1'b0;
        drive(1'b0, 13); send_frame(8, 5'b10110, 0, 1'b1);

        // Reset in the middle of data module 5.
        drive(1'b0, 20);
        drive(1'b1, 8); drive(1'b0, 8); drive(1'b1, 8);
        drive(1'b1, 8); drive(1'b0, 8); drive(1'b1, 3);
        pulse_reset();
        drive(1'b0, 20); send_frame(8, 5'b01001, 0, 1'b1);

        drive(1'b0, 20); send_frame(4, 5'b00000, 0, 1'b1);
        drive(1'b0, 20); send_frame(4, 5'b11111, 0, 1'b1);
        drive(1'b0, 20); send_frame(200, 5'b00000, 0, 1'b1);
        drive(1'b0, 20); send_frame(200, 5'b11111, 0, 1'b1);
        drive(1'b0, 20); send_frame(200, 5'b10101, 3, 1'b1);

        for (int i = 0; i < 30; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) w = $urandom_range(1, 3);
            else if (sel == 1) w = $urandom_range(201, 240);
            else if (sel == 2) w = 4;
            else w = $urandom_range(4, 24);
            fault = $urandom_range(0, 6);
            if (fault > 3) fault = 0;
            drive(1'b0, $urandom_range(16, 30));
            send_frame(w, 5'($urandom_range(0, 31)), fault, 1'b1);
        end

        drive(1'b0, 40);
        chk_end = 1'b1;
        @(negedge clock); #1;
        chk_end = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barcode_frame_decoder.md
# barcode_frame_decoder

Front-end stage of the bar-code reader. It samples the raw serial bar signal from the optical sensor and learns the module width from the start guard. It decodes one 5-bit item code per scanned frame, checks parity and guards, and presents the code with a one-cycle strobe. Its output feeds the 5-bit item input `I[4:0]` of the payment/dispense controller.

## Interface
Parameters:
- `CW`, 8: width of all cycle counters.
- `MIN_W`, 4: minimum legal module width in cycles. Must be ≥ 2.
- `MAX_W`, 200: maximum legal module width in cycles. Must be < 2^CW.
- `IDLE_CYCLES`, 16: consecutive white cycles required before a frame is armed.

Ports:
- `clock`  in  1: single clock; all logic on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `bar_in`  in  1: raw sensor level (1 = black), asynchronous to `clock`.
- `code`  out  5: last decoded item code; connects to the controller's `I[4:0]`.
- `code_valid`  out  1: one-cycle pulse when `code` has just been updated.
- `err`  out  1: one-cycle pulse on any rejected frame.
- `busy`  out  1: high from the start-guard rising edge until the frame is accepted or rejected.

## Operation
- `bar_in` passes through a 2-flop synchronizer. All of the following refers to the synchronized signal `s`.
- Frame format: each module is W cycles wide.
  - Modules 0–2: start guard black / white / black.
  - Modules 3–7: data bits d4..d0 (black = 1).
  - Module 8: even-parity bit, so d4..d0 plus parity contain an even number of ones.
  - Module 9: stop module, black.
- ARM state: count consecutive `s`=0 cycles, saturating at `IDLE_CYCLES`. Any `s`=1 clears the count. When count = `IDLE_CYCLES` and `s`=1 is seen, go to MEASURE with the width counter = 1 and `busy`=1.
- MEASURE: increment the width counter while `s`=1.
  - Width saturates at MAX_W+1, which counts as overflow.
  - On the first `s`=0 cycle (t0), latch W = count.
  - If W < MIN_W or W > MAX_W, reject. Otherwise go to SAMPLE with the phase counter = 1 and module index m = 1.
- SAMPLE: module m spans cycles t0+(m−1)·W … t0+m·W−1 and is sampled at t0+(m−1)·W+floor(W/2).
  - m=1 must be 0.
  - m=2 must be 1.
  - m=3..7 shift into a data register, MSB first.
  - m=8 is the parity bit.
  - m=9 must be 1.
  - A guard mismatch rejects immediately on its sample cycle. No further samples are taken.
- Accept: on the m=9 sample, if the stop bit and parity are good, `code` ← data register and `code_valid` pulses.
- Reject: `err` pulses and `code` keeps its old value.
- Accept and reject both return to ARM with the idle count = 0, so a fresh white gap is mandatory between frames.
- Bars arriving while ARM is not yet satisfied are ignored; they only reset the idle count.

## Timing
- Reset values: `code`=0, `code_valid`=0, `err`=0, `busy`=0, state ARM, idle count 0. The block must see `IDLE_CYCLES` of white after reset before accepting anything.
- Reset asserted mid-frame aborts the frame. No `code_valid` or `err` follows.
- Synchronizer latency: 2 cycles from `bar_in` to `s`.
- `code_valid` and `err` are registered and assert the cycle after the deciding sample:
  - accept at t0+8W+floor(W/2)+1, with `code` updated on the same edge;
  - reject at the cycle after the failing sample, or at t0+1 for a width fault.
- `busy` falls on the same edge that `code_valid` or `err` rises.
- `code_valid` and `err` are never high together. Each is high for exactly one cycle per frame.
- The phase counter wraps from W−1 to 0 at each module boundary. W=MIN_W and W=MAX_W are legal. Counters must not overflow at `CW`=8 with W=200.
- No backpressure: the downstream must capture `code` on `code_valid`. `code` stays stable until the next accepted frame.

## Test plan
- W=8, ≥16 idle cycles, then data 10110 with parity 1 and stop 1 → `code`=5'b10110, one `code_valid` pulse at t0+69 (synchronized time), `err` stays 0.
- Same frame with parity bit 0 → `err` pulse, `code` keeps its previous value, no `code_valid`.
- Start black run of 3 cycles (below MIN_W=4) → `err` at t0+1. Black run of 250 cycles → `err` after the saturation/overflow decision. Neither produces `code_valid`.
- Second frame started only 5 white cycles after an accepted frame → ignored (`busy` stays 0). The same frame after a 16-cycle gap decodes normally.
- Assert `reset` for 1 cycle during data module 5 → all outputs 0 the next cycle, no pulse. The following frame after ≥16 idle cycles decodes correctly.
- W=4 and W=200 frames carrying 00000 (parity 0) and 11111 (parity 1) → codes 0x00 and 0x1F accepted with the exact latencies above.
